// File: rtl/spawn_pkg.sv
// Shared definitions for the spawn coordinate generator: default geometry,
// retry limit and the FSM state encoding.
package spawn_pkg;

  // Default geometry: 10x12 tile playfield addressed with 4-bit coordinates.
  localparam int DEF_COORD_W   = 4;
  localparam int DEF_GRID_W    = 10;
  localparam int DEF_GRID_H    = 12;
  localparam int DEF_MAX_TRIES = 8;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAW_X = 3'd1;
  localparam logic [2:0] ST_DRAW_Y = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    DRAW_X = ST_DRAW_X,
    DRAW_Y = ST_DRAW_Y,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/spawn_axis_sampler.sv
// Rejection sampler for one axis.
//  clk, reset : clock, synchronous active-high reset
//  cand       : candidate coordinate taken from the random byte this cycle
//  en         : sampler is drawing this cycle
//  clear      : start of a new request (drops try count and fold flag)
//  accept     : combinational, this cycle's draw ends the axis
//  coord      : latched coordinate for the axis
//  fb         : the latched coordinate came from the fold path
module spawn_axis_sampler #(
  parameter int COORD_W   = 4,
  parameter int LIMIT     = 10,
  parameter int MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cand,
  input  logic               en,
  input  logic               clear,
  output logic               accept,
  output logic [COORD_W-1:0] coord,
  output logic               fb
);

  localparam int                 TRY_W     = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0]   TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0]   TRY_ONE   = TRY_W'(1);
  localparam logic [COORD_W:0]   LIMIT_EXT = (COORD_W + 1)'(LIMIT);
  // Because LIMIT > 2^(COORD_W-1), any rejected candidate minus LIMIT lands in range.
  localparam logic [COORD_W-1:0] LIMIT_LOW = COORD_W'(LIMIT);

  logic [TRY_W-1:0]   tries_r;
  logic [COORD_W-1:0] coord_r;
  logic               fb_r;
  logic               in_range_s;
  logic               last_try_s;

  assign in_range_s = ({1'b0, cand} < LIMIT_EXT);
  assign last_try_s = (tries_r == TRY_LAST);
  assign accept     = en & (in_range_s | last_try_s);
  assign coord      = coord_r;
  assign fb         = fb_r;

  // Try counter, coordinate latch and fold flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tries_r <= '0;
      coord_r <= '0;
      fb_r    <= 1'b0;
    end else if (clear) begin
      tries_r <= '0;
      fb_r    <= 1'b0;
    end else if (en) begin
      if (in_range_s) begin
        coord_r <= cand;
        tries_r <= '0;
      end else if (last_try_s) begin
        coord_r <= cand - LIMIT_LOW;
        fb_r    <= 1'b1;
        tries_r <= '0;
      end else begin
        tries_r <= tries_r + TRY_ONE;
      end
    end
  end

endmodule

// File: rtl/spawn_pos_gen.sv
// Spawn coordinate generator: turns the free-running LFSR byte into a uniform
// in-range (x,y) tile that avoids the player's tile.
//  clk, reset         : clock, synchronous active-high reset
//  num_in             : random byte, new value every cycle
//  req                : spawn request, honoured only when idle
//  player_x/player_y  : player tile, compared in the CHECK cycle
//  busy               : high whenever a request is in progress
//  valid              : one-cycle pulse, spawn_x/spawn_y/fallback are fresh
//  spawn_x/spawn_y    : result coordinates, held until the next valid
//  fallback           : at least one axis used the fold path
module spawn_pos_gen
  import spawn_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         num_in,
  input  logic               req,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic               busy,
  output logic               valid,
  output logic [COORD_W-1:0] spawn_x,
  output logic [COORD_W-1:0] spawn_y,
  output logic               fallback
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] X_ONE   = COORD_W'(1);

  state_t             state_r, next_state_s;
  logic               clear_s, en_x_s, en_y_s;
  logic               accept_x_s, accept_y_s;
  logic [COORD_W-1:0] x_coord_s, y_coord_s, final_x_s;
  logic               fb_x_s, fb_y_s;
  logic               busy_r, valid_r, fallback_r;
  logic [COORD_W-1:0] spawn_x_r, spawn_y_r;

  // x draws from the low bits, y from the high bits of the same random byte.
  spawn_axis_sampler #(.COORD_W(COORD_W), .LIMIT(GRID_W), .MAX_TRIES(MAX_TRIES)) u_x (
    .clk(clk), .reset(reset), .cand(num_in[COORD_W-1:0]), .en(en_x_s), .clear(clear_s),
    .accept(accept_x_s), .coord(x_coord_s), .fb(fb_x_s)
  );

  spawn_axis_sampler #(.COORD_W(COORD_W), .LIMIT(GRID_H), .MAX_TRIES(MAX_TRIES)) u_y (
    .clk(clk), .reset(reset), .cand(num_in[7:8-COORD_W]), .en(en_y_s), .clear(clear_s),
    .accept(accept_y_s), .coord(y_coord_s), .fb(fb_y_s)
  );

  // Next-state logic and per-state sampler controls.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    en_x_s       = 1'b0;
    en_y_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          next_state_s = DRAW_X;
          clear_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAW_X: begin
        en_x_s = 1'b1;
        if (accept_x_s) begin
          next_state_s = DRAW_Y;
        end else begin
          next_state_s = DRAW_X;
        end
      end
      DRAW_Y: begin
        en_y_s = 1'b1;
        if (accept_y_s) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = DRAW_Y;
        end
      end
      CHECK:   next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Player collision bump: step x one tile right, wrapping at the grid edge.
  always_comb begin
    final_x_s = x_coord_s;
    if ((x_coord_s == player_x) && (y_coord_s == player_y)) begin
      if (x_coord_s == X_LAST) begin
        final_x_s = '0;
      end else begin
        final_x_s = x_coord_s + X_ONE;
      end
    end else begin
      final_x_s = x_coord_s;
    end
  end

  // State register and registered outputs; results are captured leaving CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      spawn_x_r  <= '0;
      spawn_y_r  <= '0;
      fallback_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      valid_r <= (next_state_s == DONE);
      if (state_r == CHECK) begin
        spawn_x_r  <= final_x_s;
        spawn_y_r  <= y_coord_s;
        fallback_r <= fb_x_s | fb_y_s;
      end
    end
  end

  assign busy     = busy_r;
  assign valid    = valid_r;
  assign spawn_x  = spawn_x_r;
  assign spawn_y  = spawn_y_r;
  assign fallback = fallback_r;

endmodule

// File: tb/tb_spawn_pos_gen.sv
// Self-checking bench for spawn_pos_gen: directed vector table, hand-written
// reset / request-overlap sequences, and random byte streams against a model.
module tb_spawn_pos_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] num_in;
  logic       req;
  logic [3:0] player_x, player_y;
  logic       busy, valid, fallback;
  logic [3:0] spawn_x, spawn_y;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  logic [7:0] stim [24];
  int         stim_n = 1;

  spawn_pos_gen dut (
    .clk(clk), .reset(reset), .num_in(num_in), .req(req),
    .player_x(player_x), .player_y(player_y),
    .busy(busy), .valid(valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .fallback(fallback)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) pulse_cnt++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] get_b(input int i);
    if (i < stim_n) return stim[i];
    return stim[stim_n-1];
  endfunction

  // Reference: plain rejection sampling over the byte stream, one byte per draw.
  task automatic ref_model(input int px, input int py,
                           output int ex, output int ey, output int efb, output int elat);
    int idx = 0;
    int v[2];
    int lim, c;
    efb = 0;
    for (int axis = 0; axis < 2; axis++) begin
      lim = (axis == 0) ? 10 : 12;
      v[axis] = 0;
      for (int t = 0; t < 8; t++) begin
        c = (axis == 0) ? (get_b(idx) % 16) : (get_b(idx) / 16);
        idx++;
        if (c < lim) begin
          v[axis] = c;
          break;
        end
        if (t == 7) begin
          v[axis] = c - lim;
          efb = 1;
        end
      end
    end
    ex = v[0];
    ey = v[1];
    if (ex == px && ey == py) ex = (ex + 1) % 10;
    elat = idx + 1;   // one edge per draw plus the CHECK edge
  endtask

  // One request: req sampled at edge E, byte stim[k] presented for edge E+1+k.
  task automatic run_req(input string nm, input int px, input int py,
                         input int ex, input int ey, input int efb, input int elat);
    bit got = 1'b0;
    int lat = 0;
    @(negedge clk);
    player_x = 4'(px);
    player_y = 4'(py);
    req = 1'b1;
    num_in = 8'h00;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) chk({nm, "_busy"}, busy, 1);
      if (valid) begin
        got = 1'b1;
        lat = n - 1;
        break;
      end
      req = 1'b0;
      num_in = get_b(n - 1);
    end
    chk({nm, "_seen"}, got, 1);
    if (got) begin
      chk({nm, "_x"}, spawn_x, ex);
      chk({nm, "_y"}, spawn_y, ey);
      chk({nm, "_fb"}, fallback, efb);
      chk({nm, "_lat"}, lat, elat);
    end
    req = 1'b0;
    @(negedge clk);
    chk({nm, "_valid_off"}, valid, 0);
    chk({nm, "_busy_off"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int nb, px, py, ex, ey, efb, elat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ex, ey, efb, elat, base, px, py;
    bit seen;

    tbl[0] = '{8'h73, 8'h73, 8'h73, 8'h73, 1, 0, 0, 3, 7, 0, 3};   // best case
    tbl[1] = '{8'h0F, 8'h0C, 8'h05, 8'h50, 4, 0, 0, 5, 5, 0, 5};   // two x rejects
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 5, 3, 1, 17};  // both axes fold
    tbl[3] = '{8'h29, 8'h29, 8'h29, 8'h29, 1, 9, 2, 0, 2, 0, 3};   // bump wraps
    tbl[4] = '{8'h24, 8'h24, 8'h24, 8'h24, 1, 4, 2, 5, 2, 0, 3};   // bump +1
    tbl[5] = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 1, 0, 0, 5, 3, 1, 10};  // x folds only
    tbl[6] = '{8'hE1, 8'hE1, 8'hE1, 8'hE1, 1, 0, 0, 1, 2, 1, 10};  // y folds only
    tbl[7] = '{8'hB9, 8'hB9, 8'hB9, 8'hB9, 1, 0, 0, 9, 11, 0, 3};  // edge tiles accepted
    tbl[8] = '{8'hCA, 8'hCA, 8'hCA, 8'hCA, 1, 0, 0, 1, 0, 1, 17};  // folds to (0,0), bumped

    reset = 1'b1; req = 1'b0; num_in = 8'h00; player_x = 4'd0; player_y = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_x", spawn_x, 0);
    chk("rst_y", spawn_y, 0);
    chk("rst_fb", fallback, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      stim[0] = tbl[i].b0; stim[1] = tbl[i].b1; stim[2] = tbl[i].b2; stim[3] = tbl[i].b3;
      stim_n = tbl[i].nb;
      run_req($sformatf("vec%0d", i), tbl[i].px, tbl[i].py,
              tbl[i].ex, tbl[i].ey, tbl[i].efb, tbl[i].elat);
    end

    // Reset while drawing y: request aborts silently, outputs clear.
    base = pulse_cnt;
    @(negedge clk);
    req = 1'b1; num_in = 8'h00;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      req = 1'b0; num_in = 8'hFF;
    end
    chk("abort_pre_busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_x", spawn_x, 0);
    chk("abort_y", spawn_y, 0);
    chk("abort_fb", fallback, 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_pulse", pulse_cnt - base, 0);
    chk("abort_idle", busy, 0);

    // req held while busy is ignored; req in the cycle after DONE is accepted.
    base = pulse_cnt;
    player_x = 4'd0; player_y = 4'd0;
    req = 1'b1; num_in = 8'h00;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      req = 1'b1; num_in = 8'h0F;
    end
    @(negedge clk);
    req = 1'b0; num_in = 8'h73;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_first_seen", seen, 1);
    chk("b2b_first_x", spawn_x, 3);
    chk("b2b_first_y", spawn_y, 7);
    req = 1'b1;                 // high through DONE (ignored) and IDLE (accepted)
    @(negedge clk);
    chk("b2b_idle_gap", busy, 0);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_second_busy", busy, 1);
    repeat (12) @(negedge clk);
    chk("b2b_pulses", pulse_cnt - base, 2);
    chk("b2b_second_x", spawn_x, 3);

    // Random byte streams against the reference model.
    for (int it = 0; it < 30; it++) begin
      stim_n = 24;
      for (int k = 0; k < 24; k++) stim[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < 8; k++) stim[k] = stim[k] | 8'h0F;
      if ($urandom_range(0, 4) == 0) begin
        px = stim[0] % 16;
        py = stim[1] / 16;
      end else begin
        px = $urandom_range(0, 9);
        py = $urandom_range(0, 11);
      end
      ref_model(px, py, ex, ey, efb, elat);
      run_req($sformatf("rnd%0d", it), px, py, ex, ey, efb, elat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
